// File: rtl/serial_sigma.sv
// Bit-serial SHA-2 sigma unit: captures one word per bit-clock frame and plays
// XOR of up to three rotate/shift taps of the previous word, LSB first.
module serial_sigma #(
  parameter int          W        = 32,
  parameter int          NTAP     = 3,
  parameter int          ROT_A    = 2,
  parameter int          ROT_B    = 13,
  parameter int          ROT_C    = 22,
  parameter logic [2:0]  SHR_MASK = 3'b000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic [$clog2(W)-1:0] counter,
  input  logic                 in,
  output logic                 out,
  output logic                 out_valid
);

  localparam int CW = $clog2(W);
  localparam int EW = 1 << CW;

  logic          bclk_prev;
  logic          cap_full;
  logic [W-1:0]  cap;
  logic [W-1:0]  play;
  logic          rise;
  logic          fall;
  logic [W-1:0]  sigma;
  logic [EW-1:0] sigma_ext;

  // Whole-word view of one tap; a shift tap simply omits the wrapped-around bits.
  function automatic logic [W-1:0] tap_vec(input logic [W-1:0] x, input int rot,
                                           input logic shr);
    logic [W-1:0] r;
    r = x >> rot;
    if (!shr && rot != 0) r = r | (x << (W - rot));
    return r;
  endfunction

  assign rise = !bclk_prev && bclk;
  assign fall = bclk_prev && !bclk;

  // Zero-extension makes counter values >= W (non-power-of-two W) select 0.
  always_comb begin
    sigma = '0;
    if (NTAP >= 1) sigma = sigma ^ tap_vec(play, ROT_A, SHR_MASK[0]);
    if (NTAP >= 2) sigma = sigma ^ tap_vec(play, ROT_B, SHR_MASK[1]);
    if (NTAP >= 3) sigma = sigma ^ tap_vec(play, ROT_C, SHR_MASK[2]);
    sigma_ext = EW'(sigma);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_prev <= 1'b0;
      cap_full  <= 1'b0;
      cap       <= '0;
      play      <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      bclk_prev <= bclk;
      if (rise) begin
        if (counter == '0) begin
          play      <= cap;
          out_valid <= cap_full;
          cap_full  <= 1'b0;
          cap[0]    <= in;
        end else if (int'(counter) < W) begin
          cap[counter] <= in;
          if (int'(counter) == W - 1) cap_full <= 1'b1;
        end
      end
      if (fall) out <= sigma_ext[counter];
    end
  end

endmodule

// File: tb/tb_serial_sigma.sv
// Scoreboard bench for serial_sigma: six configurations share one bit stream;
// expected words are queued when a frame is driven and checked while played.
module tb_serial_sigma;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       bclk = 1'b0;
  logic       din  = 1'b0;
  logic [5:0] cnt  = '0;
  logic [5:0] outBit;
  logic [5:0] outVld;

  int total = 0;
  int bad   = 0;

  int         cfgW    [6] = '{32, 32, 32, 32, 32, 64};
  int         cfgNtap [6] = '{1, 3, 3, 3, 3, 3};
  int         cfgRa   [6] = '{8, 2, 6, 7, 7, 28};
  int         cfgRb   [6] = '{0, 13, 11, 18, 18, 34};
  int         cfgRc   [6] = '{0, 22, 25, 3, 3, 39};
  logic [2:0] cfgMask [6] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};

  typedef struct packed {
    logic [5:0][63:0] exp;
    logic [5:0]       vld;
  } entry_t;

  entry_t      sb[$];
  logic [63:0] capModel = '0;

  always #5 clk = ~clk;

  serial_sigma #(.W(32), .NTAP(1), .ROT_A(8), .ROT_B(0), .ROT_C(0), .SHR_MASK(3'b000)) u0 (
    .clk(clk), .rst(rst), .bclk(bclk), .counter(cnt[4:0]), .in(din),
    .out(outBit[0]), .out_valid(outVld[0]));
  serial_sigma #(.W(32), .NTAP(3), .ROT_A(2), .ROT_B(13), .ROT_C(22), .SHR_MASK(3'b000)) u1 (
    .clk(clk), .rst(rst), .bclk(bclk), .counter(cnt[4:0]), .in(din),
    .out(outBit[1]), .out_valid(outVld[1]));
  serial_sigma #(.W(32), .NTAP(3), .ROT_A(6), .ROT_B(11), .ROT_C(25), .SHR_MASK(3'b000)) u2 (
    .clk(clk), .rst(rst), .bclk(bclk), .counter(cnt[4:0]), .in(din),
    .out(outBit[2]), .out_valid(outVld[2]));
  serial_sigma #(.W(32), .NTAP(3), .ROT_A(7), .ROT_B(18), .ROT_C(3), .SHR_MASK(3'b100)) u3 (
    .clk(clk), .rst(rst), .bclk(bclk), .counter(cnt[4:0]), .in(din),
    .out(outBit[3]), .out_valid(outVld[3]));
  serial_sigma #(.W(32), .NTAP(3), .ROT_A(7), .ROT_B(18), .ROT_C(3), .SHR_MASK(3'b000)) u4 (
    .clk(clk), .rst(rst), .bclk(bclk), .counter(cnt[4:0]), .in(din),
    .out(outBit[4]), .out_valid(outVld[4]));
  serial_sigma #(.W(64), .NTAP(3), .ROT_A(28), .ROT_B(34), .ROT_C(39), .SHR_MASK(3'b000)) u5 (
    .clk(clk), .rst(rst), .bclk(bclk), .counter(cnt), .in(din),
    .out(outBit[5]), .out_valid(outVld[5]));

  // Per-bit reference: each tap reads bit k+rot, wrapping only for rotate taps.
  function automatic logic [63:0] refSigma(input logic [63:0] x, input int i);
    logic [63:0] r;
    int          rots[3];
    int          idx;
    logic        b;
    r = '0;
    rots[0] = cfgRa[i];
    rots[1] = cfgRb[i];
    rots[2] = cfgRc[i];
    for (int k = 0; k < cfgW[i]; k++) begin
      b = 1'b0;
      for (int t = 0; t < cfgNtap[i]; t++) begin
        idx = k + rots[t];
        if (idx < cfgW[i]) b = b ^ x[6'(idx)];
        else if (!cfgMask[i][t]) b = b ^ x[6'(idx - cfgW[i])];
      end
      r[6'(k)] = b;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushEntry(input logic full);
    entry_t e;
    for (int i = 0; i < 6; i++) begin
      e.exp[i] = refSigma(capModel, i);
      e.vld[i] = full;
    end
    sb.push_back(e);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    bclk = 1'b0;
    rst  = 1'b1;
    #1;
    checkOutput({tag, "_out"}, 64'(outBit), 64'd0);
    checkOutput({tag, "_valid"}, 64'(outVld), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    capModel = '0;
    sb.delete();
    pushEntry(1'b0);
  endtask

  // Drives nbits periods of one frame and checks the word played meanwhile.
  task automatic applyStimulus(input logic [63:0] word, input int nbits, input int wlen);
    logic [63:0] got  [6];
    logic        vAll [6];
    logic        vAny [6];
    logic [63:0] m;
    entry_t      e;
    for (int i = 0; i < 6; i++) begin
      got[i]  = '0;
      vAll[i] = 1'b1;
      vAny[i] = 1'b0;
    end
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      cnt = 6'(k);
      din = word[6'(k)];
      @(negedge clk);
      bclk = 1'b1;
      repeat (3) @(negedge clk);
      bclk = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        got[i][6'(k)] = outBit[i];
        vAll[i] = vAll[i] & outVld[i];
        vAny[i] = vAny[i] | outVld[i];
      end
      capModel[6'(k)] = word[6'(k)];
    end
    m = (nbits >= 64) ? '1 : ((64'd1 << nbits) - 64'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty: got size 0 expected 1");
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < 6; i++) begin
        if (cfgW[i] == wlen) begin
          checkOutput($sformatf("out_u%0d_w%h", i, word), got[i] & m, e.exp[i] & m);
          checkOutput($sformatf("valid_u%0d_w%h", i, word), {62'd0, vAny[i], vAll[i]},
                      {62'd0, e.vld[i], e.vld[i]});
        end
      end
    end
    pushEntry(nbits == wlen);
  endtask

  initial begin
    doReset("reset0");
    applyStimulus(64'h0000_00FF, 32, 32);
    applyStimulus(64'h0000_0000, 32, 32);
    applyStimulus(64'h6a09_e667, 32, 32);
    applyStimulus(64'h510e_527f, 32, 32);
    applyStimulus(64'h8000_0000, 32, 32);
    applyStimulus(64'h0000_0001, 32, 32);
    applyStimulus(64'hDEAD_BEEF, 32, 32);
    applyStimulus(64'h1234_5678, 32, 32);
    applyStimulus(64'h0F0F_0F0F, 32, 32);
    applyStimulus(64'hA5A5_C3C3, 16, 32);
    applyStimulus(64'h1357_9BDF, 32, 32);
    applyStimulus(64'h2468_ACE0, 32, 32);
    applyStimulus(64'hCAFE_F00D, 11, 32);
    doReset("reset_mid");
    applyStimulus(64'h55AA_33CC, 32, 32);
    applyStimulus(64'h0000_0000, 32, 32);

    doReset("reset64");
    applyStimulus(64'h6a09e667f3bcc908, 64, 64);
    applyStimulus(64'h0123456789abcdef, 64, 64);
    applyStimulus(64'h0000000000000000, 64, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
